// File: rtl/alu_path_ctrl_pkg.sv
// Shared codes for the multicycle ALU-path sequencer: state encoding,
// operand/ALU select codes, opcode/funct constants and funct decode helpers.
// Latency: n/a (declarations only). Backpressure: n/a.
package alu_path_ctrl_pkg;

    // Sequencer states. RST must stay at zero so the reset state reads as 0
    // on state_dbg.
    typedef enum logic [4:0] {
        ST_RST     = 5'd0,
        ST_FETCH   = 5'd1,
        ST_DECODE  = 5'd2,
        ST_EXEC_R  = 5'd3,
        ST_EXEC_I  = 5'd4,
        ST_EXEC_IZ = 5'd5,
        ST_ADDR    = 5'd6,
        ST_MEM_RD  = 5'd7,
        ST_MEM_WR  = 5'd8,
        ST_WB_R    = 5'd9,
        ST_WB_I    = 5'd10,
        ST_WB_MEM  = 5'd11,
        ST_BRANCH  = 5'd12,
        ST_JUMP    = 5'd13,
        ST_OVF     = 5'd14,
        ST_ILLEGAL = 5'd15
    } state_t;

    // ALU B-operand source select (101..111 are never driven)
    localparam logic [2:0] ALUSRCB_BREG     = 3'b000;
    localparam logic [2:0] ALUSRCB_FOUR     = 3'b001;
    localparam logic [2:0] ALUSRCB_SIMM     = 3'b010;
    localparam logic [2:0] ALUSRCB_SIMM_SH2 = 3'b011;
    localparam logic [2:0] ALUSRCB_ZIMM     = 3'b100;

    // ALU operation select
    localparam logic [2:0] ALUOP_ADD = 3'b000;
    localparam logic [2:0] ALUOP_SUB = 3'b001;
    localparam logic [2:0] ALUOP_AND = 3'b010;
    localparam logic [2:0] ALUOP_SLT = 3'b100;

    // PC load source
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Supported opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Supported R-type functs
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    // One control word per cycle, bundled for the output decode
    typedef struct packed {
        logic       alusrc_a;
        logic [2:0] alusrc_b;
        logic [2:0] alu_op;
        logic       aluout_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       exc_ovf;
        logic       exc_opcode;
    } ctrl_word_t;

    function automatic logic funct_valid(input logic [5:0] f);
        logic ok;
        ok = (f == FUNCT_ADD) || (f == FUNCT_SUB) ||
             (f == FUNCT_AND) || (f == FUNCT_SLT);
        return ok;
    endfunction

    // Only add/sub trap on signed overflow; and/slt never do
    function automatic logic funct_traps(input logic [5:0] f);
        logic t;
        t = (f == FUNCT_ADD) || (f == FUNCT_SUB);
        return t;
    endfunction

    function automatic logic [2:0] funct_aluop(input logic [5:0] f);
        logic [2:0] op;
        case (f)
            FUNCT_SUB: op = ALUOP_SUB;
            FUNCT_AND: op = ALUOP_AND;
            FUNCT_SLT: op = ALUOP_SLT;
            default:   op = ALUOP_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_path_ctrl_mem_wait_ctr.sv
// Memory wait counter: counts 0..MEM_LAT-1 while enabled, done on the last count.
// Latency: done is combinational from the count register.
// Backpressure: none; clr wins over en and restarts the count at zero.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   clr    synchronous clear (asserted whenever the sequencer changes state)
//   en     count enable (memory-access states only)
//   done   count has reached MEM_LAT-1
module alu_path_ctrl_mem_wait_ctr #(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam logic [2:0] LAST = 3'(MEM_LAT - 1);

    logic [2:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !done) begin
            cnt <= cnt + 3'd1;
        end
    end

    // With MEM_LAT=1 LAST is 0, so every access completes in its first cycle
    assign done = (cnt == LAST);

endmodule

// File: rtl/alu_path_ctrl.sv
// Multicycle sequencer issuing one Moore control word per cycle to the ALU datapath.
// Latency: fetch/load/store take MEM_LAT cycles, every other state one cycle.
// Backpressure: none; memory is assumed to complete in exactly MEM_LAT cycles.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   opcode, funct         IR fields, valid from DECODE onward
//   zero, overflow        ALU flags, same cycle
//   alusrc_a, alusrc_b    ALU operand selects
//   alu_op                ALU operation
//   aluout_write          latch ALU result into ALUOut
//   pc_write, pc_src      PC load enable and source
//   ir_write              IR load enable
//   mem_read, mem_write   memory strobes
//   reg_write, reg_dst, mem_to_reg   regfile write controls
//   exc_ovf, exc_opcode   one-cycle exception pulses
//   state_dbg             current state encoding
module alu_path_ctrl
    import alu_path_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    output logic       alusrc_a,
    output logic [2:0] alusrc_b,
    output logic [2:0] alu_op,
    output logic       aluout_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       exc_ovf,
    output logic       exc_opcode,
    output logic [4:0] state_dbg
);

    state_t     state;
    state_t     next_state;
    logic       wait_done;
    logic       mem_phase;
    ctrl_word_t cw;

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RST;
        end else begin
            state <= next_state;
        end
    end

    assign mem_phase = (state == ST_FETCH) || (state == ST_MEM_RD) ||
                       (state == ST_MEM_WR);

    // Counter restarts on every state change, so each access sees a fresh
    // count even when two memory states are adjacent.
    alu_path_ctrl_mem_wait_ctr #(
        .MEM_LAT (MEM_LAT)
    ) u_wait (
        .clk   (clk),
        .reset (reset),
        .clr   (next_state != state),
        .en    (mem_phase),
        .done  (wait_done)
    );

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            ST_RST:    next_state = ST_FETCH;
            ST_FETCH:  if (wait_done) next_state = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:     next_state = funct_valid(funct) ? ST_EXEC_R : ST_ILLEGAL;
                    OP_ADDI:      next_state = ST_EXEC_I;
                    OP_ANDI:      next_state = ST_EXEC_IZ;
                    OP_LW, OP_SW: next_state = ST_ADDR;
                    OP_BEQ, OP_BNE: next_state = ST_BRANCH;
                    OP_J:         next_state = ST_JUMP;
                    default:      next_state = ST_ILLEGAL;
                endcase
            end
            // Trapping here keeps the overflowing result out of the regfile
            ST_EXEC_R:  next_state = (overflow && funct_traps(funct)) ? ST_OVF : ST_WB_R;
            ST_EXEC_I:  next_state = overflow ? ST_OVF : ST_WB_I;
            ST_EXEC_IZ: next_state = ST_WB_I;
            // Only lw/sw reach ADDR, so anything but lw is a store
            ST_ADDR:    next_state = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:  if (wait_done) next_state = ST_WB_MEM;
            ST_MEM_WR:  if (wait_done) next_state = ST_FETCH;
            ST_WB_R, ST_WB_I, ST_WB_MEM,
            ST_BRANCH, ST_JUMP, ST_OVF, ST_ILLEGAL: next_state = ST_FETCH;
            default:    next_state = ST_FETCH;
        endcase
    end

    // ---------------------------------------------------------------
    // Output decode (state + wait counter; branch pc_write also uses zero)
    // ---------------------------------------------------------------
    always_comb begin
        cw = '0;
        case (state)
            ST_FETCH: begin
                cw.mem_read = 1'b1;
                cw.alusrc_b = ALUSRCB_FOUR;
                cw.alu_op   = ALUOP_ADD;
                // PC+4 and IR are committed only once the read data is valid
                if (wait_done) begin
                    cw.ir_write = 1'b1;
                    cw.pc_write = 1'b1;
                    cw.pc_src   = PCSRC_ALU;
                end
            end
            ST_DECODE: begin
                // Speculative branch target into ALUOut
                cw.alusrc_b     = ALUSRCB_SIMM_SH2;
                cw.alu_op       = ALUOP_ADD;
                cw.aluout_write = 1'b1;
            end
            ST_EXEC_R: begin
                cw.alusrc_a     = 1'b1;
                cw.alusrc_b     = ALUSRCB_BREG;
                cw.alu_op       = funct_aluop(funct);
                cw.aluout_write = 1'b1;
            end
            ST_EXEC_I: begin
                cw.alusrc_a     = 1'b1;
                cw.alusrc_b     = ALUSRCB_SIMM;
                cw.alu_op       = ALUOP_ADD;
                cw.aluout_write = 1'b1;
            end
            ST_EXEC_IZ: begin
                cw.alusrc_a     = 1'b1;
                cw.alusrc_b     = ALUSRCB_ZIMM;
                cw.alu_op       = ALUOP_AND;
                cw.aluout_write = 1'b1;
            end
            ST_ADDR: begin
                cw.alusrc_a     = 1'b1;
                cw.alusrc_b     = ALUSRCB_SIMM;
                cw.alu_op       = ALUOP_ADD;
                cw.aluout_write = 1'b1;
            end
            ST_MEM_RD: cw.mem_read  = 1'b1;
            ST_MEM_WR: cw.mem_write = 1'b1;
            ST_WB_R: begin
                cw.reg_write = 1'b1;
                cw.reg_dst   = 1'b1;
            end
            ST_WB_I: cw.reg_write = 1'b1;
            ST_WB_MEM: begin
                cw.reg_write  = 1'b1;
                cw.mem_to_reg = 1'b1;
            end
            ST_BRANCH: begin
                cw.alusrc_a = 1'b1;
                cw.alusrc_b = ALUSRCB_BREG;
                cw.alu_op   = ALUOP_SUB;
                cw.pc_write = (opcode == OP_BEQ) ? zero : !zero;
                cw.pc_src   = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                cw.pc_write = 1'b1;
                cw.pc_src   = PCSRC_JUMP;
            end
            ST_OVF:     cw.exc_ovf    = 1'b1;
            ST_ILLEGAL: cw.exc_opcode = 1'b1;
            default: ;
        endcase
    end

    assign alusrc_a     = cw.alusrc_a;
    assign alusrc_b     = cw.alusrc_b;
    assign alu_op       = cw.alu_op;
    assign aluout_write = cw.aluout_write;
    assign pc_write     = cw.pc_write;
    assign pc_src       = cw.pc_src;
    assign ir_write     = cw.ir_write;
    assign mem_read     = cw.mem_read;
    assign mem_write    = cw.mem_write;
    assign reg_write    = cw.reg_write;
    assign reg_dst      = cw.reg_dst;
    assign mem_to_reg   = cw.mem_to_reg;
    assign exc_ovf      = cw.exc_ovf;
    assign exc_opcode   = cw.exc_opcode;
    assign state_dbg    = state;

endmodule
